// File: rtl/spdif_pair_fifo_pkg.sv
// rtl/spdif_pair_fifo_pkg.sv - shared widths, pairing states and saturating increment
package spdif_pair_fifo_pkg;

  localparam int SAMPLE_W = 24;
  localparam int FRAME_W  = 48;

  typedef enum logic {
    WAIT_L = 1'b0,
    HAVE_L = 1'b1
  } pair_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/spdif_pair_fifo_if.sv
// rtl/spdif_pair_fifo_if.sv - receiver sample strobes in, stereo frame handshake out
interface spdif_pair_fifo_if;
  import spdif_pair_fifo_pkg::*;

  logic [SAMPLE_W-1:0] sample_i;
  logic                ack_i;
  logic                lrck_i;
  logic                locked_i;
  logic [FRAME_W-1:0]  frame_o;
  logic                valid_o;
  logic                ready_i;

  modport slave (
    input  sample_i, ack_i, lrck_i, locked_i, ready_i,
    output frame_o, valid_o
  );

  modport master (
    output sample_i, ack_i, lrck_i, locked_i, ready_i,
    input  frame_o, valid_o
  );

endinterface

// File: rtl/spdif_pair_fifo_sync_fifo.sv
// rtl/spdif_pair_fifo_sync_fifo.sv - first-word fall-through synchronous FIFO
module sync_fifo #(
  parameter int WIDTH      = 48,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   fill_o
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam logic [FILL_W-1:0]     FULL_LVL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0]     FILL_ONE = FILL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  rd_fire, wr_fire;

  // A write into a full FIFO is still accepted when a pop frees a slot this cycle.
  assign rd_fire = rd_en_i & ~empty_o;
  assign wr_fire = wr_en_i & (~full_o | rd_fire);

  always_comb begin
    fill_d = fill_q;
    case ({wr_fire, rd_fire})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (wr_fire) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      fill_q <= fill_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (fill_q == FULL_LVL);
  assign empty_o   = (fill_q == '0);
  assign fill_o    = fill_q;

endmodule

// File: rtl/spdif_pair_fifo.sv
// rtl/spdif_pair_fifo.sv - pairs left/right subframes into stereo frames and buffers them
module spdif_pair_fifo
  import spdif_pair_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int PERIOD_W        = 12,
  parameter int CNT_W           = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  spdif_pair_fifo_if.slave           bus,
  input  logic                       clear_i,
  output logic [CNT_W-1:0]           orphan_count_o,
  output logic [CNT_W-1:0]           drop_count_o,
  output logic [PERIOD_W-1:0]        period_o,
  output logic [FIFO_DEPTH_LOG2:0]   fill_o
);

  localparam logic [31:0] CNT_MAX    = 32'({CNT_W{1'b1}});
  localparam logic [31:0] PERIOD_MAX = 32'({PERIOD_W{1'b1}});

  pair_state_t         state_q, state_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [CNT_W-1:0]    orphan_q, orphan_d, drop_q, drop_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d, period_q, period_d;
  logic                seen_q, seen_d;
  logic                orphan_inc, pair_wr, pop, drop, fifo_full, fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_L;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    orphan_inc = 1'b0;
    pair_wr    = 1'b0;
    if (!bus.locked_i) begin
      state_d = WAIT_L;
      left_d  = '0;
    end else if (bus.ack_i) begin
      case (state_q)
        WAIT_L: begin
          if (bus.lrck_i) begin
            orphan_inc = 1'b1;
          end else begin
            left_d  = bus.sample_i;
            state_d = HAVE_L;
          end
        end
        HAVE_L: begin
          if (bus.lrck_i) begin
            pair_wr = 1'b1;
            state_d = WAIT_L;
          end else begin
            left_d     = bus.sample_i;
            orphan_inc = 1'b1;
          end
        end
        default: state_d = WAIT_L;
      endcase
    end
  end

  assign pop  = bus.valid_o & bus.ready_i;
  assign drop = pair_wr & fifo_full & ~pop;

  always_comb begin
    orphan_d = orphan_q;
    drop_d   = drop_q;
    if (clear_i) begin
      orphan_d = '0;
      drop_d   = '0;
    end else begin
      if (orphan_inc) orphan_d = CNT_W'(sat_inc(32'(orphan_q), CNT_MAX));
      if (drop)       drop_d   = CNT_W'(sat_inc(32'(drop_q), CNT_MAX));
    end
  end

  // The first pair after lock only starts the measurement; period needs two pairs.
  always_comb begin
    pcnt_d   = pcnt_q;
    period_d = period_q;
    seen_d   = seen_q;
    if (!bus.locked_i) begin
      pcnt_d   = '0;
      period_d = '0;
      seen_d   = 1'b0;
    end else if (pair_wr) begin
      pcnt_d = '0;
      seen_d = 1'b1;
      if (seen_q) period_d = PERIOD_W'(sat_inc(32'(pcnt_q), PERIOD_MAX));
    end else begin
      pcnt_d = PERIOD_W'(sat_inc(32'(pcnt_q), PERIOD_MAX));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q   <= '0;
      orphan_q <= '0;
      drop_q   <= '0;
      pcnt_q   <= '0;
      period_q <= '0;
      seen_q   <= 1'b0;
    end else begin
      left_q   <= left_d;
      orphan_q <= orphan_d;
      drop_q   <= drop_d;
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      seen_q   <= seen_d;
    end
  end

  sync_fifo #(
    .WIDTH      (FRAME_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (pair_wr),
    .wr_data_i ({left_q, bus.sample_i}),
    .rd_en_i   (pop),
    .rd_data_o (bus.frame_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .fill_o    (fill_o)
  );

  assign bus.valid_o    = ~fifo_empty;
  assign orphan_count_o = orphan_q;
  assign drop_count_o   = drop_q;
  assign period_o       = period_q;

endmodule

// File: tb/tb_spdif_pair_fifo.sv
// tb/tb_spdif_pair_fifo.sv - directed stimulus with a queue-based reference model
module tb_spdif_pair_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic [7:0]  orphan_count_o, drop_count_o;
  logic [11:0] period_o;
  logic [2:0]  fill_o;

  int checks = 0;
  int errors = 0;

  spdif_pair_fifo_if bus ();

  spdif_pair_fifo #(
    .FIFO_DEPTH_LOG2 (2),
    .PERIOD_W        (12),
    .CNT_W           (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .clear_i        (clear_i),
    .orphan_count_o (orphan_count_o),
    .drop_count_o   (drop_count_o),
    .period_o       (period_o),
    .fill_o         (fill_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames as a queue, counts as plain integers.
  logic [47:0] m_q[$];
  bit          m_have = 0;
  logic [23:0] m_left = '0;
  int          m_orphan = 0, m_drop = 0, m_pcnt = 0, m_period = 0;
  bit          m_seen = 0;
  bit          m_pop, m_full, m_push;
  int          m_next;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_have = 0; m_left = '0; m_orphan = 0; m_drop = 0;
      m_pcnt = 0; m_period = 0; m_seen = 0;
    end else begin
      m_pop  = (m_q.size() > 0) && bus.ready_i;
      m_full = (m_q.size() == 4);
      m_push = 0;
      if (!bus.locked_i) begin
        m_have = 0; m_pcnt = 0; m_period = 0; m_seen = 0;
      end else begin
        m_next = (m_pcnt < 4095) ? m_pcnt + 1 : 4095;
        if (bus.ack_i) begin
          if (!bus.lrck_i) begin
            if (m_have && m_orphan < 255) m_orphan++;
            m_left = bus.sample_i;
            m_have = 1;
          end else if (m_have) begin
            m_push = 1;
            m_have = 0;
          end else if (m_orphan < 255) begin
            m_orphan++;
          end
        end
        if (m_push) begin
          if (m_seen) m_period = (m_pcnt + 1 > 4095) ? 4095 : m_pcnt + 1;
          m_seen = 1;
          m_next = 0;
        end
        m_pcnt = m_next;
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        if (m_full && !m_pop) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_q.push_back({m_left, bus.sample_i});
        end
      end
      if (clear_i) begin
        m_orphan = 0;
        m_drop   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", bus.valid_o, m_q.size() != 0);
      chk("fill", fill_o, m_q.size());
      if (m_q.size() != 0) chk("frame", bus.frame_o, m_q[0]);
      chk("orphan", orphan_count_o, m_orphan);
      chk("drop", drop_count_o, m_drop);
      chk("period", period_o, m_period);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic lr, input logic [23:0] data);
    bus.ack_i    = 1'b1;
    bus.lrck_i   = lr;
    bus.sample_i = data;
    tick();
    bus.ack_i = 1'b0;
  endtask

  initial begin
    bus.sample_i = '0;
    bus.ack_i    = 1'b0;
    bus.lrck_i   = 1'b0;
    bus.locked_i = 1'b1;
    bus.ready_i  = 1'b1;
    tick();
    tick();
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_frame", bus.frame_o, 48'h0);
    chk("rst_fill", fill_o, 3'd0);
    rst = 1'b0;
    tick();

    // basic pair and pop
    send(1'b0, 24'h123456);
    send(1'b1, 24'hABCDEF);
    chk("t1_valid", bus.valid_o, 1'b1);
    chk("t1_frame", bus.frame_o, 48'h123456ABCDEF);
    tick();
    chk("t1_fill_after_pop", fill_o, 3'd0);

    // orphans: R, L, L, R
    send(1'b1, 24'h111111);
    send(1'b0, 24'h222222);
    send(1'b0, 24'h333333);
    send(1'b1, 24'h444444);
    chk("t2_orphan", orphan_count_o, 8'd2);
    chk("t2_frame", bus.frame_o, 48'h333333444444);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("t2_clear", orphan_count_o, 8'd0);

    // overflow
    bus.ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(1'b0, 24'h100000 + 24'(i));
      send(1'b1, 24'h200000 + 24'(i));
    end
    chk("t3_fill", fill_o, 3'd4);
    chk("t3_drop", drop_count_o, 8'd2);
    send(1'b0, 24'h777777);
    bus.ready_i = 1'b1;
    send(1'b1, 24'h888888);
    chk("t3_full_pushpop_fill", fill_o, 3'd4);
    chk("t3_full_pushpop_drop", drop_count_o, 8'd2);
    repeat (5) tick();
    chk("t3_drained", fill_o, 3'd0);

    // period measurement
    bus.locked_i = 1'b0;
    tick();
    chk("t4_unlocked_period", period_o, 12'd0);
    bus.locked_i = 1'b1;
    tick();
    send(1'b0, 24'h0A0A0A);
    send(1'b1, 24'h0B0B0B);
    chk("t4_first_period", period_o, 12'd0);
    send(1'b0, 24'h0C0C0C);
    repeat (126) tick();
    send(1'b1, 24'h0D0D0D);
    chk("t4_period_128", period_o, 12'd128);
    send(1'b0, 24'h0E0E0E);
    bus.locked_i = 1'b0;
    tick();
    chk("t4_unlock_period", period_o, 12'd0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    bus.locked_i = 1'b1;
    send(1'b1, 24'h0F0F0F);
    chk("t4_held_left_discarded", orphan_count_o, 8'd1);

    // saturation and clear priority
    bus.ack_i  = 1'b1;
    bus.lrck_i = 1'b1;
    repeat (300) tick();
    bus.ack_i = 1'b0;
    chk("t5_orphan_sat", orphan_count_o, 8'd255);
    bus.ack_i = 1'b1;
    clear_i   = 1'b1;
    tick();
    bus.ack_i = 1'b0;
    clear_i   = 1'b0;
    chk("t5_clear_priority", orphan_count_o, 8'd0);

    // async reset mid-frame
    send(1'b1, 24'h555555);
    bus.ready_i = 1'b0;
    send(1'b0, 24'h010101);
    send(1'b1, 24'h020202);
    send(1'b0, 24'h030303);
    send(1'b1, 24'h040404);
    chk("t5_pre_period", period_o, 12'd2);
    send(1'b0, 24'h050505);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", bus.valid_o, 1'b0);
    chk("t5_rst_fill", fill_o, 3'd0);
    chk("t5_rst_frame", bus.frame_o, 48'h0);
    chk("t5_rst_orphan", orphan_count_o, 8'd0);
    chk("t5_rst_period", period_o, 12'd0);
    #3;
    rst = 1'b0;
    tick();
    send(1'b1, 24'h060606);
    chk("t5_post_rst_orphan", orphan_count_o, 8'd1);
    chk("t5_post_rst_fill", fill_o, 3'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spdif_pair_fifo.md
# spdif_pair_fifo

Stereo pairing and buffering stage directly downstream of the S/PDIF receiver (the DAI block). It consumes the receiver's per-subframe 24-bit sample strobes together with their channel flag and lock status, and assembles left/right pairs into 48-bit stereo frames. Frames are buffered in a small synchronous FIFO and presented to the mixer core over a valid/ready handshake. The block also reports pairing errors, overflow drops and the measured frame period.

## Interface
- `FIFO_DEPTH_LOG2`, 2: FIFO holds 2^N stereo frames (4).
- `PERIOD_W`, 12: width of the frame-period measurement.
- `CNT_W`, 8: width of the saturating error counters.

- `clk`  in  1  system clock, same domain as the receiver.
- `rst`  in  1  reset, asynchronous, active-high.
- `sample_i`  in  24  receiver sample, valid when `ack_i`=1.
- `ack_i`  in  1  one-cycle strobe, one new sample.
- `lrck_i`  in  1  channel of the current subframe: 0 = left (B/M preamble), 1 = right (W preamble). Stable when `ack_i`=1.
- `locked_i`  in  1  receiver lock status.
- `frame_o`  out  48  {left[23:0], right[23:0]} at the FIFO head.
- `valid_o`  out  1  FIFO not empty.
- `ready_i`  in  1  consumer accepts; pop occurs when `valid_o & ready_i`.
- `clear_i`  in  1  synchronous pulse that zeroes both error counters.
- `orphan_count_o`  out  CNT_W  unpaired or out-of-order samples, saturating.
- `drop_count_o`  out  CNT_W  frames lost to a full FIFO, saturating.
- `period_o`  out  PERIOD_W  clk cycles between the last two completed pairs. 0 means unknown.
- `fill_o`  out  FIFO_DEPTH_LOG2+1  current FIFO occupancy.

## Operation
- Pairing FSM with two states, `WAIT_L` and `HAVE_L`. Reset state is `WAIT_L`.
- `WAIT_L`, `ack_i & !lrck_i`: latch `sample_i` into the left holding register, then go to `HAVE_L`.
- `WAIT_L`, `ack_i & lrck_i`: discard the sample, increment the orphan count, stay in `WAIT_L`.
- `HAVE_L`, `ack_i & lrck_i`: write {held left, `sample_i`} to the FIFO, then go to `WAIT_L`.
- `HAVE_L`, `ack_i & !lrck_i`: the previous left was orphaned. Overwrite the held left, increment the orphan count, stay in `HAVE_L`.
- `locked_i`=0: force `WAIT_L` and discard any held left. This is not counted as an orphan. `ack_i` is ignored while unlocked. FIFO contents are retained and remain poppable.
- FIFO write when full and no pop in the same cycle: the frame is discarded and `drop_count_o` increments.
- Full and pop in the same cycle as a write: both happen, occupancy is unchanged, and nothing is dropped.
- Pop when empty: impossible, because `valid_o`=0.
- Counters saturate at all-ones and do not wrap.
- `clear_i` has priority over a same-cycle increment; the result is 0.
- Period: a free-running counter increments every clk while locked and saturates at all-ones.
  - On each pair write attempt (including dropped frames), `period_o` <= counter+1 (saturated) and the counter is set to 0.
  - The first pair after lock sets the counter only; `period_o` stays 0 until the second pair.
  - While unlocked, the counter and `period_o` are both 0.
- FIFO pointers are FIFO_DEPTH_LOG2 bits and wrap naturally. Occupancy is tracked as a separate counter.

## Timing
- All outputs reset to 0: `frame_o`, `valid_o`, counters, `period_o`, `fill_o`. The holding register and FIFO storage also reset to 0.
- Latency: right-channel `ack_i` sampled at edge N → FIFO written at edge N → `valid_o`=1 and `frame_o` valid after edge N (one cycle, provided the FIFO was empty).
- `frame_o` is the registered head entry (first-word fall-through). It updates on the edge after each pop.
- `fill_o` and `valid_o` update on the same edge as the write or pop.
- Error counters update on the edge that samples the causing event.
- Reset asserted mid-operation clears everything asynchronously. The first sample after release is treated as if in `WAIT_L`.

## Structure
- The shared package holds `SAMPLE_W=24`, `FRAME_W=48`, the FSM state encodings, and a `sat_inc` helper function.
- One natural sub-module: `sync_fifo` (parameterised width/depth, first-word fall-through, full/empty/fill outputs, async active-high reset). It is reusable elsewhere in the mixer.
- Pairing FSM, counters and period measurement stay in the top level.

## Test plan
- Locked; acks L=0x123456 then R=0xABCDEF, `ready_i`=1 → one cycle later `valid_o`=1, `frame_o`=0x123456ABCDEF. Popped next edge; `fill_o` back to 0.
- Sequence R, L, L, R → `orphan_count_o`=2, exactly one frame containing the second L; `clear_i` pulse → count 0.
- `ready_i`=0, push 6 pairs → `fill_o`=4, `drop_count_o`=2. Then a pop and a push in the same cycle while full → `fill_o` stays 4, no drop.
- Pairs every 128 clk (first pair at lock) → `period_o`=0 after the first pair, 128 after the second; drop `locked_i` → `period_o`=0, held left discarded.
- 300 orphan acks → `orphan_count_o`=255 (saturated). Assert `rst` asynchronously mid-frame → all outputs 0 immediately, FSM in `WAIT_L`.
